campfire_checkpoint: RTL and testbench
======================================

CAMPFIRE_CHECKPOINT -- requirements
Module: campfire_checkpoint

Interface
REQ-001 SHALL have parameter CAMPFIRE_W, default 16, campfire hitbox width in pixels.
REQ-002 SHALL have parameter CAMPFIRE_H, default 16, campfire hitbox height in pixels.
REQ-003 SHALL have parameter PLAYER_W, default 16, player hitbox width in pixels.
REQ-004 SHALL have parameter PLAYER_H, default 16, player hitbox height in pixels.
REQ-005 SHALL have parameter IGNITE_TICKS, default 30, frame ticks of continuous interaction needed to light the fire.
REQ-006 SHALL have parameter FLAME_FRAMES, default 6, flame animation frame count (at most 8).
REQ-007 SHALL have parameter FLAME_DIV, default 4, frame ticks per animation frame.
REQ-008 SHALL have parameter SPAWN_X, default 10'd20, default respawn x.
REQ-009 SHALL have parameter SPAWN_Y, default 10'd200, default respawn y.
REQ-010 SHALL have port sim_clk, input, 1, sole clock; all state changes on its rising edge.
REQ-011 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-012 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-013 SHALL have port campfireState, input, 32, campfire x in [31:22] and y in [21:12], with [11:0] ignored.
REQ-014 SHALL have port playerState, input, 32, player x in [31:22] and y in [21:12], with [11:0] ignored.
REQ-015 SHALL have port interact, input, 1, level-sensitive interact button.
REQ-016 SHALL have port checkpointState, output, 32, packed as {respawnX[9:0], respawnY[9:0], state[1:0], flameFrame[2:0], lit, 6'b0}.
REQ-017 SHALL have port save_pulse, output, 1, one-cycle strobe when the checkpoint is saved.

Function
REQ-018 SHALL compute overlap combinationally as an AABB test using 11-bit sums: px < cx+CAMPFIRE_W, px+PLAYER_W > cx, py < cy+CAMPFIRE_H, py+PLAYER_H > cy; no wrap at x or y near 1023.
REQ-019 SHALL define engaged as overlap AND interact.
REQ-020 SHALL implement FSM states UNLIT=2'd0, IGNITING=2'd1, LIT=2'd2, driven on checkpointState[11:10]; encoding 2'd3 SHALL fall back to UNLIT on the next cycle.
REQ-021 In UNLIT, engaged SHALL move the FSM to IGNITING next cycle with the ignite counter at 0.
REQ-022 In IGNITING, the ignite counter SHALL increment on each frame_tick while engaged.
REQ-023 In IGNITING, if engaged is low in any cycle, the FSM SHALL return to UNLIT and clear the counter; this check takes priority over a simultaneous frame_tick.
REQ-024 In IGNITING, the frame_tick that brings the counter to IGNITE_TICKS SHALL, on that edge: enter LIT, latch respawnX=cx, latch respawnY=cy-PLAYER_H (saturating at 0), and assert save_pulse for exactly the next cycle.
REQ-025 LIT SHALL be terminal until reset.
REQ-026 In LIT, a rising edge of interact (registered previous value 0, current 1) while overlap is high SHALL re-latch respawn from the current campfireState and pulse save_pulse once.
REQ-027 Holding interact in LIT SHALL NOT produce further pulses.
REQ-028 Campfire position changes in LIT SHALL NOT alter respawn until the next re-save.
REQ-029 lit SHALL equal (state==LIT).
REQ-030 In LIT, flameFrame SHALL advance every FLAME_DIV frame_ticks and wrap from FLAME_FRAMES-1 to 0.
REQ-031 Outside LIT, flameFrame and its divider SHALL be held at 0.
REQ-032 The flame divider SHALL start from 0 on LIT entry.
REQ-033 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-034 Asserting reset_n=0 SHALL immediately, without a clock, force: state=UNLIT, counters=0, flameFrame=0, lit=0, save_pulse=0, respawnX=SPAWN_X, respawnY=SPAWN_Y, interact history=0.
REQ-035 Reset during IGNITING or mid-save_pulse SHALL abort the operation with no residual pulse.
REQ-036 Reset deassertion SHALL take effect at the first rising sim_clk after reset_n=1.

Verification
REQ-037 Reset then idle: checkpointState reads {10'd20, 10'd200, 12'b0}; save_pulse stays 0.
REQ-038 Campfire (250,180), player (245,180), interact held, 30 frame_ticks -> state=2, lit=1, respawn=(250,164), one save_pulse, checkpointState[31:12]={10'd250, 10'd164}.
REQ-039 Same setup, interact released after 29 ticks -> state=0, no save_pulse, respawn stays (20,200); a new press restarts the count from 0.
REQ-040 Lit, 24 frame_ticks with defaults -> flameFrame sequence 0,1,2,3,4,5,0 at 4-tick spacing.
REQ-041 Lit, campfire moved to (600,10), player overlapping, interact 0->1 -> respawn=(600,0) saturated, exactly one pulse; interact held for 100 cycles -> no further pulse.
REQ-042 reset_n pulsed low mid-IGNITING and in the save_pulse cycle -> outputs return to reset values asynchronously; player at x=1020 versus campfire x=0 -> no overlap.

Source files
------------

// File: rtl/campfire_checkpoint.sv
// campfire_checkpoint
//   Campfire checkpoint controller. The player lights the fire by standing on
//   it and holding interact for IGNITE_TICKS frame ticks. Once lit, the
//   respawn point is latched above the campfire and the flame animates. A
//   fresh interact press while overlapping re-saves the respawn point.
//
// Ports
//   sim_clk         : sole clock, rising edge
//   reset_n         : asynchronous active-low reset
//   frame_tick      : one-cycle pulse per video frame
//   campfireState   : {x[9:0], y[9:0], 12'(ignored)}
//   playerState     : {x[9:0], y[9:0], 12'(ignored)}
//   interact        : level-sensitive interact button
//   checkpointState : {respawnX, respawnY, state[1:0], flameFrame[2:0], lit, 6'b0}
//   save_pulse      : one-cycle strobe on every checkpoint save
module campfire_checkpoint #(
  parameter int unsigned CAMPFIRE_W   = 16,
  parameter int unsigned CAMPFIRE_H   = 16,
  parameter int unsigned PLAYER_W     = 16,
  parameter int unsigned PLAYER_H     = 16,
  parameter int unsigned IGNITE_TICKS = 30,
  parameter int unsigned FLAME_FRAMES = 6,
  parameter int unsigned FLAME_DIV    = 4,
  parameter logic [9:0]  SPAWN_X      = 10'd20,
  parameter logic [9:0]  SPAWN_Y      = 10'd200
) (
  input  logic        sim_clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic [31:0] campfireState,
  input  logic [31:0] playerState,
  input  logic        interact,
  output logic [31:0] checkpointState,
  output logic        save_pulse
);

  localparam int unsigned CNT_W = $clog2(IGNITE_TICKS) + 1;
  localparam int unsigned DIV_W = $clog2(FLAME_DIV) + 1;

  typedef enum logic [1:0] {
    UNLIT    = 2'd0,
    IGNITING = 2'd1,
    LIT      = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   ignite_cnt_q;
  logic [DIV_W-1:0]   flame_div_q;
  logic [2:0]         flame_frame_q;
  logic               save_pulse_q;
  logic [9:0]         respawn_x_q;
  logic [9:0]         respawn_y_q;
  logic               interact_q;

  logic [9:0]  cx, cy, px, py;
  logic        overlap;
  logic        engaged;
  logic        interact_rise;
  logic [9:0]  respawn_y_d;
  logic        unused_lsbs;

  assign cx = campfireState[31:22];
  assign cy = campfireState[21:12];
  assign px = playerState[31:22];
  assign py = playerState[21:12];
  assign unused_lsbs = ^{campfireState[11:0], playerState[11:0]};

  // Sums carried in 11 bits so objects near x/y = 1023 never wrap to 0.
  assign overlap = ({1'b0, px} < ({1'b0, cx} + 11'(CAMPFIRE_W))) &&
                   (({1'b0, px} + 11'(PLAYER_W)) > {1'b0, cx}) &&
                   ({1'b0, py} < ({1'b0, cy} + 11'(CAMPFIRE_H))) &&
                   (({1'b0, py} + 11'(PLAYER_H)) > {1'b0, cy});

  assign engaged       = overlap && interact;
  assign interact_rise = interact && !interact_q;

  // Respawn sits one player-height above the campfire, clamped at the top row.
  assign respawn_y_d = ({1'b0, cy} >= 11'(PLAYER_H)) ?
                       10'({1'b0, cy} - 11'(PLAYER_H)) : '0;

  always_ff @(posedge sim_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= UNLIT;
      ignite_cnt_q  <= '0;
      flame_div_q   <= '0;
      flame_frame_q <= '0;
      save_pulse_q  <= 1'b0;
      respawn_x_q   <= SPAWN_X;
      respawn_y_q   <= SPAWN_Y;
      interact_q    <= 1'b0;
    end else begin
      interact_q   <= interact;
      save_pulse_q <= 1'b0;
      case (state_q)
        UNLIT: begin
          ignite_cnt_q  <= '0;
          flame_div_q   <= '0;
          flame_frame_q <= '0;
          if (engaged) begin
            state_q <= IGNITING;
          end
        end
        IGNITING: begin
          flame_div_q   <= '0;
          flame_frame_q <= '0;
          // Losing engagement wins over a coincident frame tick.
          if (!engaged) begin
            state_q      <= UNLIT;
            ignite_cnt_q <= '0;
          end else if (frame_tick) begin
            if (ignite_cnt_q == CNT_W'(IGNITE_TICKS - 1)) begin
              state_q      <= LIT;
              ignite_cnt_q <= '0;
              respawn_x_q  <= cx;
              respawn_y_q  <= respawn_y_d;
              save_pulse_q <= 1'b1;
            end else begin
              ignite_cnt_q <= ignite_cnt_q + 1'b1;
            end
          end
        end
        LIT: begin
          if (interact_rise && overlap) begin
            respawn_x_q  <= cx;
            respawn_y_q  <= respawn_y_d;
            save_pulse_q <= 1'b1;
          end
          if (frame_tick) begin
            if (flame_div_q == DIV_W'(FLAME_DIV - 1)) begin
              flame_div_q <= '0;
              if (flame_frame_q == 3'(FLAME_FRAMES - 1)) begin
                flame_frame_q <= '0;
              end else begin
                flame_frame_q <= flame_frame_q + 1'b1;
              end
            end else begin
              flame_div_q <= flame_div_q + 1'b1;
            end
          end
        end
        default: begin
          state_q       <= UNLIT;
          ignite_cnt_q  <= '0;
          flame_div_q   <= '0;
          flame_frame_q <= '0;
        end
      endcase
    end
  end

  assign checkpointState = {respawn_x_q, respawn_y_q, state_q, flame_frame_q,
                            (state_q == LIT), 6'b0};
  assign save_pulse      = save_pulse_q;

endmodule

// File: tb/tb_campfire_checkpoint.sv
module tb_campfire_checkpoint;

  logic        sim_clk;
  logic        reset_n;
  logic        frame_tick;
  logic [31:0] campfireState;
  logic [31:0] playerState;
  logic        interact;
  logic [31:0] checkpointState;
  logic        save_pulse;

  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned pulse_cnt;

  campfire_checkpoint #(
    .CAMPFIRE_W  (16),
    .CAMPFIRE_H  (16),
    .PLAYER_W    (16),
    .PLAYER_H    (16),
    .IGNITE_TICKS(30),
    .FLAME_FRAMES(6),
    .FLAME_DIV   (4),
    .SPAWN_X     (10'd20),
    .SPAWN_Y     (10'd200)
  ) dut (
    .sim_clk        (sim_clk),
    .reset_n        (reset_n),
    .frame_tick     (frame_tick),
    .campfireState  (campfireState),
    .playerState    (playerState),
    .interact       (interact),
    .checkpointState(checkpointState),
    .save_pulse     (save_pulse)
  );

  initial sim_clk = 1'b0;
  always #5 sim_clk = ~sim_clk;

  // Count strobes on the falling edge, away from the active edge.
  initial pulse_cnt = 0;
  always @(negedge sim_clk) if (save_pulse === 1'b1) pulse_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pos(input logic [9:0] x, input logic [9:0] y);
    return {x, y, 12'h000};
  endfunction

  task automatic cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge sim_clk);
  endtask

  task automatic tick();
    @(negedge sim_clk);
    frame_tick = 1'b1;
    @(negedge sim_clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    @(negedge sim_clk);
    interact   = 1'b0;
    frame_tick = 1'b0;
    reset_n    = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    frame_tick    = 1'b0;
    interact      = 1'b0;
    campfireState = pos(10'd250, 10'd180);
    playerState   = pos(10'd600, 10'd600);
    cycles(3);
    n_checks++;
    if (checkpointState !== {10'd20, 10'd200, 12'b0}) begin
      n_fail++;
      $display("FAIL reset_word: got %h, required %h", checkpointState, {10'd20, 10'd200, 12'b0});
    end
    n_checks++;
    if (save_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulse: got %b, required 0", save_pulse);
    end
    reset_n = 1'b1;
    ticks(10);
    n_checks++;
    if (checkpointState !== {10'd20, 10'd200, 12'b0}) begin
      n_fail++;
      $display("FAIL idle_word: got %h, required %h", checkpointState, {10'd20, 10'd200, 12'b0});
    end
    n_checks++;
    if (pulse_cnt !== 0) begin
      n_fail++;
      $display("FAIL idle_pulses: got %0d, required 0", pulse_cnt);
    end
  endtask

  task automatic test_ignite();
    int unsigned base;
    apply_reset();
    base          = pulse_cnt;
    campfireState = pos(10'd250, 10'd180);
    playerState   = pos(10'd245, 10'd180);
    interact      = 1'b1;
    cycles(2);
    n_checks++;
    if (checkpointState[11:10] !== 2'd1) begin
      n_fail++;
      $display("FAIL ignite_enter: state got %0d, required 1", checkpointState[11:10]);
    end
    ticks(29);
    n_checks++;
    if (checkpointState[11:10] !== 2'd1 || pulse_cnt - base !== 0) begin
      n_fail++;
      $display("FAIL ignite_29: state got %0d pulses got %0d, required state 1 pulses 0",
               checkpointState[11:10], pulse_cnt - base);
    end
    tick();
    cycles(3);
    n_checks++;
    if (checkpointState !== {10'd250, 10'd164, 2'd2, 3'd0, 1'b1, 6'b0}) begin
      n_fail++;
      $display("FAIL ignite_lit_word: got %h, required %h", checkpointState,
               {10'd250, 10'd164, 2'd2, 3'd0, 1'b1, 6'b0});
    end
    n_checks++;
    if (pulse_cnt - base !== 1) begin
      n_fail++;
      $display("FAIL ignite_pulses: got %0d, required 1", pulse_cnt - base);
    end
  endtask

  task automatic test_abort();
    int unsigned base;
    apply_reset();
    base          = pulse_cnt;
    campfireState = pos(10'd250, 10'd180);
    playerState   = pos(10'd245, 10'd180);
    interact      = 1'b1;
    cycles(2);
    ticks(29);
    interact = 1'b0;
    cycles(2);
    n_checks++;
    if (checkpointState !== {10'd20, 10'd200, 12'b0} || pulse_cnt - base !== 0) begin
      n_fail++;
      $display("FAIL abort_word: got %h pulses %0d, required %h pulses 0", checkpointState,
               pulse_cnt - base, {10'd20, 10'd200, 12'b0});
    end
    // A fresh press must count from zero again.
    interact = 1'b1;
    cycles(2);
    ticks(29);
    n_checks++;
    if (checkpointState[11:10] !== 2'd1 || pulse_cnt - base !== 0) begin
      n_fail++;
      $display("FAIL abort_restart: state got %0d pulses %0d, required state 1 pulses 0",
               checkpointState[11:10], pulse_cnt - base);
    end
    tick();
    cycles(1);
    n_checks++;
    if (checkpointState[11:6] !== {2'd2, 3'd0, 1'b1} || pulse_cnt - base !== 1) begin
      n_fail++;
      $display("FAIL abort_relight: bits[11:6] got %b pulses %0d, required 100001 pulses 1",
               checkpointState[11:6], pulse_cnt - base);
    end
  endtask

  task automatic test_flame();
    logic [2:0] exp_frame [24] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2,
                                   3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4,
                                   3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5, 3'd0};
    n_checks++;
    if (checkpointState[9:7] !== 3'd0) begin
      n_fail++;
      $display("FAIL flame_start: got %0d, required 0", checkpointState[9:7]);
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      n_checks++;
      if (checkpointState[9:7] !== exp_frame[i]) begin
        n_fail++;
        $display("FAIL flame_tick%0d: got %0d, required %0d", i + 1, checkpointState[9:7],
                 exp_frame[i]);
      end
    end
  endtask

  task automatic test_resave();
    int unsigned base;
    base     = pulse_cnt;
    interact = 1'b0;
    cycles(2);
    campfireState = pos(10'd600, 10'd10);
    playerState   = pos(10'd600, 10'd10);
    cycles(3);
    n_checks++;
    if (checkpointState[31:12] !== {10'd250, 10'd164} || pulse_cnt - base !== 0) begin
      n_fail++;
      $display("FAIL resave_moved: respawn got %h pulses %0d, required %h pulses 0",
               checkpointState[31:12], pulse_cnt - base, {10'd250, 10'd164});
    end
    interact = 1'b1;
    cycles(3);
    n_checks++;
    if (checkpointState[31:12] !== {10'd600, 10'd0} || pulse_cnt - base !== 1) begin
      n_fail++;
      $display("FAIL resave_press: respawn got %h pulses %0d, required %h pulses 1",
               checkpointState[31:12], pulse_cnt - base, {10'd600, 10'd0});
    end
    cycles(100);
    n_checks++;
    if (pulse_cnt - base !== 1 || checkpointState[11:10] !== 2'd2) begin
      n_fail++;
      $display("FAIL resave_hold: pulses got %0d state %0d, required pulses 1 state 2",
               pulse_cnt - base, checkpointState[11:10]);
    end
    // A press away from the fire does nothing.
    interact    = 1'b0;
    playerState = pos(10'd0, 10'd500);
    campfireState = pos(10'd100, 10'd300);
    cycles(2);
    interact = 1'b1;
    cycles(3);
    n_checks++;
    if (pulse_cnt - base !== 1 || checkpointState[31:12] !== {10'd600, 10'd0}) begin
      n_fail++;
      $display("FAIL resave_far: pulses got %0d respawn %h, required pulses 1 respawn %h",
               pulse_cnt - base, checkpointState[31:12], {10'd600, 10'd0});
    end
  endtask

  task automatic test_async_reset();
    int unsigned base;
    apply_reset();
    campfireState = pos(10'd250, 10'd180);
    playerState   = pos(10'd245, 10'd180);
    interact      = 1'b1;
    cycles(2);
    ticks(5);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (checkpointState !== {10'd20, 10'd200, 12'b0}) begin
      n_fail++;
      $display("FAIL areset_igniting: got %h, required %h", checkpointState,
               {10'd20, 10'd200, 12'b0});
    end
    interact = 1'b0;
    apply_reset();
    base     = pulse_cnt;
    interact = 1'b1;
    cycles(2);
    ticks(29);
    @(negedge sim_clk);
    frame_tick = 1'b1;
    @(posedge sim_clk);
    #1 frame_tick = 1'b0;
    n_checks++;
    if (save_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_prepulse: save_pulse got %b, required 1", save_pulse);
    end
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (save_pulse !== 1'b0 || checkpointState !== {10'd20, 10'd200, 12'b0}) begin
      n_fail++;
      $display("FAIL areset_pulse: pulse %b word %h, required pulse 0 word %h", save_pulse,
               checkpointState, {10'd20, 10'd200, 12'b0});
    end
    interact = 1'b0;
    cycles(2);
    n_checks++;
    if (pulse_cnt - base !== 0) begin
      n_fail++;
      $display("FAIL areset_residual: pulses got %0d, required 0", pulse_cnt - base);
    end
    reset_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_no_wrap();
    apply_reset();
    campfireState = pos(10'd0, 10'd100);
    playerState   = pos(10'd1020, 10'd100);
    interact      = 1'b1;
    cycles(3);
    n_checks++;
    if (checkpointState[11:10] !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_far: state got %0d, required 0", checkpointState[11:10]);
    end
    // Genuine overlap right at the edge of the playfield.
    interact = 1'b0;
    cycles(1);
    campfireState = pos(10'd1015, 10'd1015);
    playerState   = pos(10'd1020, 10'd1020);
    interact      = 1'b1;
    cycles(3);
    n_checks++;
    if (checkpointState[11:10] !== 2'd1) begin
      n_fail++;
      $display("FAIL wrap_edge: state got %0d, required 1", checkpointState[11:10]);
    end
    interact = 1'b0;
    cycles(2);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_ignite();
    test_abort();
    test_flame();
    test_resave();
    test_async_reset();
    test_no_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
